// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and types for the register-file access scheduler
package rf_pkg;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 16;
  typedef struct packed {
    logic rp;
    logic r2p;
  } rf_prio_t;
  typedef struct packed {
    logic [RF_DATA_WIDTH-1:0] din;
    logic [RF_ADDR_WIDTH-1:0] wad1;
    logic                     wen1;
    logic [RF_ADDR_WIDTH-1:0] rad1;
    logic [RF_ADDR_WIDTH-1:0] rad2;
    logic                     ren1;
    logic                     ren2;
  } rf_issue_t;
endpackage

// File: rtl/rf_grant_arb.sv
// rf_grant_arb: collision-free grant selection for W/R1/R2 plus the rotating priority bits
module rf_grant_arb import rf_pkg::*; #(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  w_valid,
  input  logic                  r1_valid,
  input  logic                  r2_valid,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [ADDR_WIDTH-1:0] r2_addr,
  output logic                  w_gnt,
  output logic                  r1_gnt,
  output logic                  r2_gnt,
  output logic [1:0]            defer_cnt
);
  rf_prio_t prio, prio_nxt;
  logic c01, c02, c12;
  logic [2:0] req, gnt, defer;
  logic [2:0][2:0] cm;
  logic [2:0][1:0] ord;
  logic [1:0] ra, rb;
  // slot 0 = W, 1 = R1, 2 = R2; ord[0] is examined first
  always_comb begin
    c01 = w_addr == r1_addr;
    c02 = w_addr == r2_addr;
    c12 = r1_addr == r2_addr;
    req = {r2_valid, r1_valid, w_valid} & {3{resetn}};
    cm[0] = {c02, c01, 1'b0};
    cm[1] = {c12, 1'b0, c01};
    cm[2] = {1'b0, c12, c02};
    ra = prio.r2p ? 2'd2 : 2'd1;
    rb = prio.r2p ? 2'd1 : 2'd2;
    ord = prio.rp ? {2'd0, rb, ra} : {rb, ra, 2'd0};
    gnt = '0;
    for (int k = 0; k < 3; k++) gnt[ord[k]] = req[ord[k]] & ~|(gnt & cm[ord[k]]);
    defer = req & ~gnt;
    prio_nxt.rp = (gnt[0] & ((defer[1] & c01) | (defer[2] & c02))) | (prio.rp & ~defer[0]);
    prio_nxt.r2p = (gnt[1] & defer[2] & c12) | (prio.r2p & ~(gnt[2] & defer[1] & c12));
    defer_cnt = {1'b0, defer[0]} + {1'b0, defer[1]} + {1'b0, defer[2]};
  end
  assign w_gnt = gnt[0];
  assign r1_gnt = gnt[1];
  assign r2_gnt = gnt[2];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) prio <= '0;
    else prio <= prio_nxt;
endmodule

// File: rtl/rf_access_sched.sv
// rf_access_sched: issues a collision-free subset of W/R1/R2 requests to a 1W2R register file
module rf_access_sched import rf_pkg::*; #(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r1_valid,
  input  logic                  r2_valid,
  output logic                  r1_ready,
  output logic                  r2_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [ADDR_WIDTH-1:0] r2_addr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_wad1,
  output logic                  rf_wen1,
  output logic [ADDR_WIDTH-1:0] rf_rad1,
  output logic [ADDR_WIDTH-1:0] rf_rad2,
  output logic                  rf_ren1,
  output logic                  rf_ren2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2,
  input  logic                  rf_collision,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic [DATA_WIDTH-1:0] rd2_data,
  output logic                  rd1_valid,
  output logic                  rd2_valid,
  output logic [CNT_WIDTH-1:0]  conflict_cnt,
  output logic                  coll_err
);
  rf_issue_t iss;
  logic w_gnt, r1_gnt, r2_gnt;
  logic [1:0] defer_cnt;
  logic [CNT_WIDTH:0] cnt_sum;
  rf_grant_arb #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
    .clk(clk), .resetn(resetn),
    .w_valid(w_valid), .r1_valid(r1_valid), .r2_valid(r2_valid),
    .w_addr(w_addr), .r1_addr(r1_addr), .r2_addr(r2_addr),
    .w_gnt(w_gnt), .r1_gnt(r1_gnt), .r2_gnt(r2_gnt),
    .defer_cnt(defer_cnt)
  );
  assign w_ready = w_gnt;
  assign r1_ready = r1_gnt;
  assign r2_ready = r2_gnt;
  assign cnt_sum = {1'b0, conflict_cnt} + (CNT_WIDTH+1)'(defer_cnt);
  // addresses and write data only move on a handshake so the file sees stable idle inputs
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      iss <= '0;
      rd1_valid <= 1'b0;
      rd2_valid <= 1'b0;
      conflict_cnt <= '0;
      coll_err <= 1'b0;
    end else begin
      iss.wen1 <= w_gnt;
      iss.ren1 <= r1_gnt;
      iss.ren2 <= r2_gnt;
      if (w_gnt) begin
        iss.wad1 <= w_addr;
        iss.din <= w_data;
      end
      if (r1_gnt) iss.rad1 <= r1_addr;
      if (r2_gnt) iss.rad2 <= r2_addr;
      rd1_valid <= iss.ren1;
      rd2_valid <= iss.ren2;
      conflict_cnt <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
      coll_err <= coll_err | rf_collision;
    end
  assign rf_din = iss.din;
  assign rf_wad1 = iss.wad1;
  assign rf_wen1 = iss.wen1;
  assign rf_rad1 = iss.rad1;
  assign rf_rad2 = iss.rad2;
  assign rf_ren1 = iss.ren1;
  assign rf_ren2 = iss.ren2;
  assign rd1_data = rd1_valid ? rf_dout1 : '0;
  assign rd2_data = rd2_valid ? rf_dout2 : '0;
endmodule

// File: tb/tb_rf_access_sched.sv
// tb_rf_access_sched: random + directed traffic against a queue-based reference model and a behavioural register file
module tb_rf_access_sched;
  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic clk = 0, resetn = 0;
  logic w_valid, r1_valid, r2_valid, w_ready, r1_ready, r2_ready;
  logic [4:0] w_addr, r1_addr, r2_addr, rf_wad1, rf_rad1, rf_rad2;
  logic [15:0] w_data, rf_din, rf_dout1, rf_dout2, rd1_data, rd2_data;
  logic rf_wen1, rf_ren1, rf_ren2, rf_collision, rd1_valid, rd2_valid, coll_err;
  logic [15:0] conflict_cnt;

  exp_t q1[$], q2[$];
  exp_t e1, e2;
  bit ev1, ev2;
  int n_cmp = 0, n_err = 0, cyc = 0, m_cnt = 0;
  bit m_rp, m_r2p, m_coll, force_coll;
  logic [15:0] shadow[32];
  logic [15:0] mem[32];

  rf_access_sched dut (
    .clk(clk), .resetn(resetn),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .r1_valid(r1_valid), .r2_valid(r2_valid), .r1_ready(r1_ready), .r2_ready(r2_ready),
    .r1_addr(r1_addr), .r2_addr(r2_addr),
    .rf_din(rf_din), .rf_wad1(rf_wad1), .rf_wen1(rf_wen1),
    .rf_rad1(rf_rad1), .rf_rad2(rf_rad2), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
    .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_collision(rf_collision),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_valid(rd1_valid), .rd2_valid(rd2_valid),
    .conflict_cnt(conflict_cnt), .coll_err(coll_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file: synchronous reset loads mem[i] = i, registered read ports
  always @(posedge clk)
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'(i);
      rf_dout1 <= '0;
      rf_dout2 <= '0;
    end else begin
      if (rf_wen1) mem[rf_wad1] <= rf_din;
      if (rf_ren1) rf_dout1 <= mem[rf_rad1];
      if (rf_ren2) rf_dout2 <= mem[rf_rad2];
    end
  assign rf_collision = force_coll
    | (rf_wen1 & rf_ren1 & (rf_wad1 == rf_rad1))
    | (rf_wen1 & rf_ren2 & (rf_wad1 == rf_rad2))
    | (rf_ren1 & rf_ren2 & (rf_rad1 == rf_rad2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: read results must appear exactly at their due cycle with the model's data
  always @(negedge clk) begin
    ev1 = q1.size() != 0 && q1[0].due == cyc;
    chk("rd1_valid", rd1_valid, ev1);
    if (ev1) begin
      e1 = q1.pop_front();
      if (rd1_valid) chk("rd1_data", rd1_data, e1.d);
    end else if (!rd1_valid) chk("rd1_data idle", rd1_data, 0);
    ev2 = q2.size() != 0 && q2[0].due == cyc;
    chk("rd2_valid", rd2_valid, ev2);
    if (ev2) begin
      e2 = q2.pop_front();
      if (rd2_valid) chk("rd2_data", rd2_data, e2.d);
    end else if (!rd2_valid) chk("rd2_data idle", rd2_data, 0);
  end

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_rp = 0;
    m_r2p = 0;
    m_cnt = 0;
    m_coll = 0;
    for (int i = 0; i < 32; i++) shadow[i] = 16'(i);
  endtask

  // one cycle: called just after a rising edge with inputs already applied
  task automatic step(input bit drop);
    bit v[3];
    bit g[3];
    logic [4:0] a[3];
    int ord[3];
    int fr, nd, i;
    @(negedge clk);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("coll_err", coll_err, m_coll);
    v[0] = w_valid; v[1] = r1_valid; v[2] = r2_valid;
    a[0] = w_addr;  a[1] = r1_addr;  a[2] = r2_addr;
    fr = m_r2p ? 2 : 1;
    if (m_rp) begin ord[0] = fr; ord[1] = 3 - fr; ord[2] = 0; end
    else begin ord[0] = 0; ord[1] = fr; ord[2] = 3 - fr; end
    g[0] = 0; g[1] = 0; g[2] = 0;
    for (int k = 0; k < 3; k++) begin
      i = ord[k];
      g[i] = v[i];
      for (int j = 0; j < 3; j++) if (j != i && g[j] && a[j] == a[i]) g[i] = 0;
    end
    chk("w_ready", w_ready, g[0]);
    chk("r1_ready", r1_ready, g[1]);
    chk("r2_ready", r2_ready, g[2]);
    nd = 0;
    for (int k = 0; k < 3; k++) if (v[k] && !g[k]) nd++;
    m_cnt = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
    if (g[0] && ((v[1] && !g[1] && a[1] == a[0]) || (v[2] && !g[2] && a[2] == a[0]))) m_rp = 1;
    else if (v[0] && !g[0]) m_rp = 0;
    if (g[1] && v[2] && !g[2] && a[1] == a[2]) m_r2p = 1;
    else if (g[2] && v[1] && !g[1] && a[1] == a[2]) m_r2p = 0;
    if (g[1]) q1.push_back('{shadow[a[1]], cyc + 2});
    if (g[2]) q2.push_back('{shadow[a[2]], cyc + 2});
    if (g[0]) shadow[a[0]] = w_data;
    if (force_coll) m_coll = 1;
    @(posedge clk);
    #1;
    if (drop) begin
      if (g[0]) w_valid = 0;
      if (g[1]) r1_valid = 0;
      if (g[2]) r2_valid = 0;
    end
  endtask

  task automatic idle(input int n);
    w_valid = 0; r1_valid = 0; r2_valid = 0;
    repeat (n) step(1);
  endtask

  task automatic do_reset();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " w_ready"}, w_ready, 0);
    chk({tag, " r1_ready"}, r1_ready, 0);
    chk({tag, " r2_ready"}, r2_ready, 0);
    chk({tag, " rf_wen1"}, rf_wen1, 0);
    chk({tag, " rf_ren1"}, rf_ren1, 0);
    chk({tag, " rf_ren2"}, rf_ren2, 0);
    chk({tag, " rf_din"}, rf_din, 0);
    chk({tag, " rf_wad1"}, rf_wad1, 0);
    chk({tag, " rf_rad1"}, rf_rad1, 0);
    chk({tag, " rf_rad2"}, rf_rad2, 0);
    chk({tag, " rd1_valid"}, rd1_valid, 0);
    chk({tag, " rd2_valid"}, rd2_valid, 0);
    chk({tag, " rd1_data"}, rd1_data, 0);
    chk({tag, " rd2_data"}, rd2_data, 0);
    chk({tag, " conflict_cnt"}, conflict_cnt, 0);
    chk({tag, " coll_err"}, coll_err, 0);
  endtask

  initial begin
    force_coll = 0;
    w_valid = 1; r1_valid = 1; r2_valid = 1;
    w_addr = 1; r1_addr = 2; r2_addr = 3; w_data = 16'h1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("por");
    resetn = 1;
    idle(2);
    // independent write then reads
    w_valid = 1; w_addr = 3; w_data = 16'hA5A5;
    step(1);
    r1_valid = 1; r1_addr = 3; r2_valid = 1; r2_addr = 7;
    step(1);
    idle(4);
    // three-way conflict on one address
    do_reset();
    w_valid = 1; w_addr = 4; w_data = 16'hBEEF;
    r1_valid = 1; r1_addr = 4; r2_valid = 1; r2_addr = 4;
    repeat (3) step(1);
    idle(4);
    // write vs R1 with R1 held until accepted
    do_reset();
    w_valid = 1; w_addr = 5; w_data = 16'h5A5A;
    r1_valid = 1; r1_addr = 5;
    repeat (2) step(1);
    idle(4);
    // R1/R2 on the same address, both reissued
    do_reset();
    r1_valid = 1; r1_addr = 9; r2_valid = 1; r2_addr = 9;
    repeat (3) step(0);
    idle(4);
    // random traffic on a narrow address window to provoke conflicts
    for (int n = 0; n < 3000; n++) begin
      if (!w_valid && $urandom_range(0, 1) == 1) begin
        w_valid = 1;
        w_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        w_data = 16'($urandom);
      end
      if (!r1_valid && $urandom_range(0, 1) == 1) begin
        r1_valid = 1;
        r1_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      end
      if (!r2_valid && $urandom_range(0, 1) == 1) begin
        r2_valid = 1;
        r2_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      end
      step(1);
    end
    idle(4);
    // saturate the conflict counter: two deferrals per cycle
    w_valid = 1; w_addr = 12; w_data = 16'hC0DE;
    r1_valid = 1; r1_addr = 12; r2_valid = 1; r2_addr = 12;
    repeat (32800) step(0);
    idle(4);
    // downstream collision makes coll_err sticky
    force_coll = 1;
    step(1);
    force_coll = 0;
    idle(4);
    // asynchronous reset between a read handshake and its return
    r1_valid = 1; r1_addr = 2;
    step(1);
    w_valid = 1; r1_valid = 1; r2_valid = 1;
    #3;
    resetn = 0;
    model_reset();
    #1;
    chk_reset_outs("async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("held");
    resetn = 1;
    idle(2);
    w_valid = 1; w_addr = 1; w_data = 16'h7E57;
    step(1);
    r1_valid = 1; r1_addr = 1;
    step(1);
    idle(4);
    chk("rd1 queue drained", q1.size(), 0);
    chk("rd2 queue drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
